// File: rtl/rob_circular_queue.sv
// Reorder buffer: circular queue of in-flight instructions. Allocates tags at issue,
// captures CDB results, retires in program order and serves one operand lookup port.
module rob_circular_queue #(
   parameter int DEPTH_LOG2 = 4,
   parameter int XLEN       = 32,
   parameter int REG_W      = 5
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_pipline,
   input  logic                  issue_valid,
   input  logic                  issue_has_dest,
   input  logic [REG_W-1:0]      issue_rd,
   input  logic                  issue_done,
   input  logic [XLEN-1:0]       issue_data,
   output logic                  issue_accept,
   output logic [DEPTH_LOG2-1:0] issue_tag,
   output logic                  rob_full,
   output logic                  rob_empty,
   input  logic                  cdb_valid,
   input  logic [DEPTH_LOG2-1:0] cdb_tag,
   input  logic [XLEN-1:0]       cdb_data,
   input  logic [DEPTH_LOG2-1:0] query_tag,
   output logic                  query_ready,
   output logic [XLEN-1:0]       query_data,
   output logic                  commit_valid,
   output logic [DEPTH_LOG2-1:0] commit_tag,
   output logic                  need_write_to_regfile,
   output logic [REG_W-1:0]      reg_id,
   output logic [XLEN-1:0]       data
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [DEPTH-1:0]      busy_q, busy_d, ready_q, ready_d, has_dest_q, has_dest_d;
   logic [REG_W-1:0]      rd_q    [DEPTH];
   logic [REG_W-1:0]      rd_d    [DEPTH];
   logic [XLEN-1:0]       value_q [DEPTH];
   logic [XLEN-1:0]       value_d [DEPTH];
   logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;

   logic                  commit_valid_q, commit_valid_d;
   logic [DEPTH_LOG2-1:0] commit_tag_q, commit_tag_d;
   logic                  need_write_q, need_write_d;
   logic [REG_W-1:0]      reg_id_q, reg_id_d;
   logic [XLEN-1:0]       data_q, data_d;

   logic retire;
   logic query_cdb_hit;

   // issue_valid/issue_accept handshake: an instruction is allocated at the rising edge
   // exactly when issue_accept is high in that cycle; the full test sees only the current
   // count, so a retire in the same cycle never makes room for the issue.
   assign rob_full     = (count_q == CW'(DEPTH));
   assign rob_empty    = (count_q == '0);
   assign issue_accept = issue_valid & rdy_in & ~flush_pipline & ~rob_full;
   assign issue_tag    = tail_q;

   assign retire = rdy_in & ~flush_pipline & busy_q[head_q] & ready_q[head_q];

   // Forward a same-cycle broadcast so a waiting station can grab the operand now.
   assign query_cdb_hit = cdb_valid & (cdb_tag == query_tag);
   assign query_ready   = busy_q[query_tag] & (ready_q[query_tag] | query_cdb_hit);
   assign query_data    = query_cdb_hit ? cdb_data : value_q[query_tag];

   assign commit_valid          = commit_valid_q;
   assign commit_tag            = commit_tag_q;
   assign need_write_to_regfile = need_write_q;
   assign reg_id                = reg_id_q;
   assign data                  = data_q;

   always_comb begin
      busy_d         = busy_q;
      ready_d        = ready_q;
      has_dest_d     = has_dest_q;
      rd_d           = rd_q;
      value_d        = value_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      need_write_d   = 1'b0;
      commit_tag_d   = commit_tag_q;
      reg_id_d       = reg_id_q;
      data_d         = data_q;
      if (rdy_in) begin
         if (flush_pipline) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (issue_accept) begin
               busy_d[tail_q]     = 1'b1;
               ready_d[tail_q]    = issue_done;
               has_dest_d[tail_q] = issue_has_dest;
               rd_d[tail_q]       = issue_rd;
               value_d[tail_q]    = issue_data;
               tail_d             = tail_q + 1'b1;
            end
            if (cdb_valid && busy_q[cdb_tag]) begin
               ready_d[cdb_tag] = 1'b1;
               value_d[cdb_tag] = cdb_data;
            end
            if (retire) begin
               busy_d[head_q] = 1'b0;
               head_d         = head_q + 1'b1;
               commit_valid_d = 1'b1;
               commit_tag_d   = head_q;
               reg_id_d       = rd_q[head_q];
               data_d         = value_q[head_q];
               need_write_d   = has_dest_q[head_q] & (rd_q[head_q] != '0);
            end
            count_d = count_q + CW'(issue_accept) - CW'(retire);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q         <= '0;
         ready_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_tag_q   <= '0;
         need_write_q   <= 1'b0;
         reg_id_q       <= '0;
         data_q         <= '0;
      end else begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_tag_q   <= commit_tag_d;
         need_write_q   <= need_write_d;
         reg_id_q       <= reg_id_d;
         data_q         <= data_d;
      end
   end

   // Payload fields are only meaningful while busy, so they carry no reset.
   always_ff @(posedge clk_in) begin
      has_dest_q <= has_dest_d;
      rd_q       <= rd_d;
      value_q    <= value_d;
   end
endmodule

// File: tb/tb_rob_circular_queue.sv
// Self-checking bench for rob_circular_queue: directed table, corner sequences and
// random traffic against a program-order queue model.
module tb_rob_circular_queue;
   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic             rst_in, rdy_in, flush_pipline;
   logic             issue_valid, issue_has_dest, issue_done;
   logic [REG_W-1:0] issue_rd;
   logic [XLEN-1:0]  issue_data;
   logic             issue_accept, rob_full, rob_empty;
   logic [DL-1:0]    issue_tag;
   logic             cdb_valid;
   logic [DL-1:0]    cdb_tag, query_tag;
   logic [XLEN-1:0]  cdb_data, query_data;
   logic             query_ready;
   logic             commit_valid, need_write_to_regfile;
   logic [DL-1:0]    commit_tag;
   logic [REG_W-1:0] reg_id;
   logic [XLEN-1:0]  data;

   rob_circular_queue #(.DEPTH_LOG2(DL), .XLEN(XLEN), .REG_W(REG_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
      .issue_valid(issue_valid), .issue_has_dest(issue_has_dest), .issue_rd(issue_rd),
      .issue_done(issue_done), .issue_data(issue_data), .issue_accept(issue_accept),
      .issue_tag(issue_tag), .rob_full(rob_full), .rob_empty(rob_empty),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .query_tag(query_tag), .query_ready(query_ready), .query_data(query_data),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .need_write_to_regfile(need_write_to_regfile), .reg_id(reg_id), .data(data)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: in-flight instructions in program order, oldest first.
   typedef struct {
      int               tag;
      logic             has_dest;
      logic [REG_W-1:0] rd;
      logic             rdy;
      logic [XLEN-1:0]  val;
   } ent_t;
   ent_t             mq[$];
   int               m_head = 0;
   logic             m_cv = 1'b0, m_nw = 1'b0, m_acc;
   int               m_ctag = 0;
   logic [REG_W-1:0] m_reg = '0;
   logic [XLEN-1:0]  m_data = '0;

   logic             got_accept, got_full, got_empty, got_qr;
   logic [DL-1:0]    got_tag;
   logic [XLEN-1:0]  got_qd;

   function automatic int find(input int tag);
      int idx;
      idx = (tag - m_head + DEPTH) % DEPTH;
      return (idx < mq.size()) ? idx : -1;
   endfunction

   task automatic model_edge();
      int   idx;
      logic ret;
      ent_t e;
      if (rst_in) begin
         mq.delete(); m_head = 0;
         m_cv = 0; m_nw = 0; m_ctag = 0; m_reg = '0; m_data = '0;
      end else if (!rdy_in) begin
         m_cv = 0; m_nw = 0;
      end else if (flush_pipline) begin
         mq.delete(); m_head = 0; m_cv = 0; m_nw = 0;
      end else begin
         ret = (mq.size() > 0) && mq[0].rdy;
         m_cv = ret;
         m_nw = 0;
         if (ret) begin
            m_ctag = mq[0].tag; m_reg = mq[0].rd; m_data = mq[0].val;
            m_nw = mq[0].has_dest && (mq[0].rd != 0);
         end
         if (cdb_valid) begin
            idx = find(int'(cdb_tag));
            if (idx >= 0) begin
               e = mq[idx]; e.rdy = 1'b1; e.val = cdb_data; mq[idx] = e;
            end
         end
         if (ret) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
         end
         if (m_acc) begin
            e.tag = (m_head + mq.size()) % DEPTH;
            e.has_dest = issue_has_dest; e.rd = issue_rd;
            e.rdy = issue_done; e.val = issue_data;
            mq.push_back(e);
         end
      end
   endtask

   // One cycle: inputs already applied after the falling edge.
   task automatic step();
      int              idx;
      logic            hit, e_qr;
      logic [XLEN-1:0] e_qd;
      #1;
      m_acc = issue_valid && rdy_in && !flush_pipline && (mq.size() < DEPTH);
      got_accept = issue_accept; got_tag = issue_tag; got_full = rob_full;
      got_empty = rob_empty; got_qr = query_ready; got_qd = query_data;
      if (!rst_in) begin
         idx  = find(int'(query_tag));
         hit  = cdb_valid && (cdb_tag == query_tag);
         e_qr = (idx >= 0) && (mq[idx].rdy || hit);
         e_qd = hit ? cdb_data : ((idx >= 0) ? mq[idx].val : '0);
         check("issue_accept", 64'(issue_accept), 64'(m_acc));
         check("issue_tag", 64'(issue_tag), 64'((m_head + mq.size()) % DEPTH));
         check("rob_full", 64'(rob_full), 64'(mq.size() == DEPTH));
         check("rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
         check("query_ready", 64'(query_ready), 64'(e_qr));
         if (e_qr) check("query_data", 64'(query_data), 64'(e_qd));
      end
      @(posedge clk_in);
      model_edge();
      #1;
      check("commit_valid", 64'(commit_valid), 64'(m_cv));
      check("need_write", 64'(need_write_to_regfile), 64'(m_nw));
      check("commit_tag", 64'(commit_tag), 64'(m_ctag));
      check("reg_id", 64'(reg_id), 64'(m_reg));
      check("commit_data", 64'(data), 64'(m_data));
      @(negedge clk_in);
   endtask

   task automatic idle();
      rst_in = 0; rdy_in = 1; flush_pipline = 0;
      issue_valid = 0; issue_has_dest = 1; issue_rd = '0; issue_done = 0; issue_data = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_data = '0; query_tag = '0;
   endtask

   task automatic do_reset();
      idle(); rst_in = 1; step(); rst_in = 0;
   endtask

   task automatic issue(input logic [REG_W-1:0] rd, input logic done, input logic [XLEN-1:0] d);
      idle(); issue_valid = 1; issue_rd = rd; issue_done = done; issue_data = d;
   endtask

   typedef struct {
      logic             iv;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  idata;
      logic             cv;
      logic [DL-1:0]    ct;
      logic [XLEN-1:0]  cd;
      logic             e_acc;
      logic [DL-1:0]    e_tag;
      logic             e_empty;
      logic             e_cv;
      logic [DL-1:0]    e_ctag;
      logic [REG_W-1:0] e_reg;
      logic [XLEN-1:0]  e_data;
   } vec_t;
   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b1, 5'd1, 32'h1, 1'b0, 4'd0, 32'h0,  1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 5'd0, 32'h0};
      tbl[1] = '{1'b1, 5'd2, 32'h2, 1'b0, 4'd0, 32'h0,  1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0};
      tbl[2] = '{1'b1, 5'd3, 32'h3, 1'b0, 4'd0, 32'h0,  1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0};
      tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 4'd2, 32'h22, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0};
      tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 4'd0, 32'h10, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0};
      tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 4'd1, 32'h11, 1'b0, 4'd3, 1'b0, 1'b1, 4'd0, 5'd1, 32'h10};
      tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 1'b0, 1'b1, 4'd1, 5'd2, 32'h11};
      tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 1'b0, 1'b1, 4'd2, 5'd3, 32'h22};
      tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 1'b1, 1'b0, 4'd2, 5'd3, 32'h22};

      idle();
      rst_in = 1;
      @(negedge clk_in);
      step();
      check("reset_commit_valid", 64'(commit_valid), 64'(0));
      check("reset_data", 64'(data), 64'(0));
      step();
      rst_in = 0;

      // Out-of-order completion, in-order retirement.
      foreach (tbl[i]) begin
         idle();
         issue_valid = tbl[i].iv; issue_rd = tbl[i].rd; issue_data = tbl[i].idata;
         cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_data = tbl[i].cd;
         step();
         check($sformatf("tbl%0d_accept", i), 64'(got_accept), 64'(tbl[i].e_acc));
         check($sformatf("tbl%0d_tag", i), 64'(got_tag), 64'(tbl[i].e_tag));
         check($sformatf("tbl%0d_empty", i), 64'(got_empty), 64'(tbl[i].e_empty));
         check($sformatf("tbl%0d_cv", i), 64'(commit_valid), 64'(tbl[i].e_cv));
         check($sformatf("tbl%0d_nw", i), 64'(need_write_to_regfile), 64'(tbl[i].e_cv));
         check($sformatf("tbl%0d_ctag", i), 64'(commit_tag), 64'(tbl[i].e_ctag));
         check($sformatf("tbl%0d_reg", i), 64'(reg_id), 64'(tbl[i].e_reg));
         check($sformatf("tbl%0d_data", i), 64'(data), 64'(tbl[i].e_data));
      end

      // Fill to full, then retire one and wrap the tail.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         issue(5'(i + 1), 1'b0, 32'(i)); step();
      end
      issue(5'd20, 1'b0, 32'h20);
      step();
      check("full_flag", 64'(got_full), 64'(1));
      check("full_no_accept", 64'(got_accept), 64'(0));
      cdb_valid = 1; cdb_tag = 4'd0; cdb_data = 32'hA0;
      step();
      cdb_valid = 0;
      step();
      check("retire_same_cycle_no_accept", 64'(got_accept), 64'(0));
      check("retire_commit", 64'(commit_valid), 64'(1));
      step();
      check("wrap_accept", 64'(got_accept), 64'(1));
      check("wrap_tag", 64'(got_tag), 64'(0));

      // Flush with concurrent issue and CDB.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(5'(i + 1), 1'b0, 32'(i)); step();
      end
      issue(5'd9, 1'b1, 32'h9);
      flush_pipline = 1; cdb_valid = 1; cdb_tag = 4'd1; cdb_data = 32'h1234;
      step();
      check("flush_no_accept", 64'(got_accept), 64'(0));
      issue(5'd7, 1'b0, 32'h7);
      step();
      check("post_flush_empty", 64'(got_empty), 64'(1));
      check("post_flush_tag", 64'(got_tag), 64'(0));
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_flush_no_commit", 64'(commit_valid), 64'(0));
      end

      // Stall with a ready head.
      do_reset();
      issue(5'd4, 1'b0, 32'h0); step();
      idle(); cdb_valid = 1; cdb_tag = 4'd0; cdb_data = 32'h77; step();
      issue(5'd6, 1'b1, 32'h66);
      rdy_in = 0; cdb_valid = 1; cdb_tag = 4'd0; cdb_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_no_commit", 64'(commit_valid), 64'(0));
         check("stall_no_accept", 64'(got_accept), 64'(0));
      end
      idle();
      step();
      check("unstall_commit", 64'(commit_valid), 64'(1));
      check("unstall_data", 64'(data), 64'(32'h77));
      check("unstall_reg", 64'(reg_id), 64'(4));
      step();
      check("unstall_single", 64'(commit_valid), 64'(0));

      // rd=0 retires without a regfile write.
      do_reset();
      issue(5'd0, 1'b1, 32'h55); step();
      idle(); step();
      check("rd0_commit", 64'(commit_valid), 64'(1));
      check("rd0_no_write", 64'(need_write_to_regfile), 64'(0));
      check("rd0_data", 64'(data), 64'(32'h55));

      // Query forwarding from the CDB, then 2-edge commit latency.
      do_reset();
      issue(5'd9, 1'b0, 32'h0); step();
      idle(); query_tag = 4'd0; cdb_valid = 1; cdb_tag = 4'd0; cdb_data = 32'hDEADBEEF;
      step();
      check("fwd_ready", 64'(got_qr), 64'(1));
      check("fwd_data", 64'(got_qd), 64'(32'hDEADBEEF));
      check("fwd_no_commit_yet", 64'(commit_valid), 64'(0));
      idle(); step();
      check("fwd_commit", 64'(commit_valid), 64'(1));
      check("fwd_commit_data", 64'(data), 64'(32'hDEADBEEF));

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst_in         = ($urandom_range(0, 199) == 0);
         rdy_in         = ($urandom_range(0, 9) != 0);
         flush_pipline  = ($urandom_range(0, 39) == 0);
         issue_valid    = ($urandom_range(0, 9) < 6);
         issue_has_dest = 1'($urandom_range(0, 1));
         issue_rd       = 5'($urandom_range(0, 31));
         issue_done     = ($urandom_range(0, 3) == 0);
         issue_data     = $urandom;
         cdb_valid      = 1'($urandom_range(0, 1));
         cdb_tag        = 4'($urandom_range(0, DEPTH - 1));
         cdb_data       = $urandom;
         query_tag      = 4'($urandom_range(0, DEPTH - 1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
